// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential radix-2 divider.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package div_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Width of the iteration counter for a given operand width
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between a divider client and seq_divider.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: master = client (drives operands, flush, out_ready); slave = divider.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_r;
    logic             out_dz;
    logic             busy;

    modport master (
        output in_valid, in_signed, in_x, in_y, flush, out_ready,
        input  in_ready, out_valid, out_q, out_r, out_dz, busy
    );

    modport slave (
        input  in_valid, in_signed, in_x, in_y, flush, out_ready,
        output in_ready, out_valid, out_q, out_r, out_dz, busy
    );
endinterface

// File: rtl/div_negate.sv
// Conditional two's-complement negate: y_o = en_i ? -a_i : a_i.
// Latency: combinational.
// Backpressure: n/a.
// Ports: en_i negate enable, a_i operand, y_o result.
module div_negate #(
    parameter int WIDTH = 32
) (
    input  logic             en_i,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = en_i ? (~a_i + WIDTH'(1)) : a_i;
endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider, signed or unsigned, WIDTH 2..64.
// Latency: WIDTH+1 edges from acceptance to out_valid; 1 edge for a zero divisor.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; flush aborts from any state.
// Ports: div_clk, rst (sync, active-high), dif (slave side of seq_divider_if).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          div_clk,
    input  logic          rst,
    seq_divider_if.slave  dif
);
    localparam int CW = cnt_width(WIDTH);

    div_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] rem_q, rem_d;      // {partial remainder, dividend/quotient bits}
    logic [WIDTH-1:0]   ymag_q, ymag_d;
    logic               sx_q, sx_d;
    logic               sy_q, sy_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               dz_q, dz_d;

    // Operand magnitudes computed straight from the request
    logic               sx_in, sy_in;
    logic [WIDTH-1:0]   xmag, ymag;

    assign sx_in = dif.in_signed & dif.in_x[WIDTH-1];
    assign sy_in = dif.in_signed & dif.in_y[WIDTH-1];

    div_negate #(.WIDTH(WIDTH)) u_abs_x (.en_i(sx_in), .a_i(dif.in_x), .y_o(xmag));
    div_negate #(.WIDTH(WIDTH)) u_abs_y (.en_i(sy_in), .a_i(dif.in_y), .y_o(ymag));

    // One restoring step: shift left, trial-subtract the divisor from the top half
    logic [2*WIDTH:0]   rem_sh;
    logic [WIDTH+1:0]   trial;
    logic               q_bit;
    logic [2*WIDTH-1:0] rem_step;

    assign rem_sh = {rem_q, 1'b0};
    assign trial  = {1'b0, rem_sh[2*WIDTH:WIDTH]} - {2'b00, ymag_q};
    // A successful subtraction leaves a value below the divisor, so both top bits are clear
    assign q_bit  = ~|trial[WIDTH+1:WIDTH];
    assign rem_step = q_bit ? {trial[WIDTH-1:0], rem_sh[WIDTH-1:1], 1'b1}
                            : rem_sh[2*WIDTH-1:0];

    // Sign fix-up applied to the final step's quotient and remainder
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    div_negate #(.WIDTH(WIDTH)) u_fix_q (.en_i(sx_q ^ sy_q), .a_i(rem_step[WIDTH-1:0]),       .y_o(quo_fix));
    div_negate #(.WIDTH(WIDTH)) u_fix_r (.en_i(sx_q),        .a_i(rem_step[2*WIDTH-1:WIDTH]), .y_o(rem_fix));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        ymag_d  = ymag_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        if (dif.flush) begin
            // Abort wins over acceptance and over the result being taken
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dif.in_valid) begin
                        sx_d   = sx_in;
                        sy_d   = sy_in;
                        ymag_d = ymag;
                        rem_d  = {{WIDTH{1'b0}}, xmag};
                        cnt_d  = '0;
                        if (dif.in_y == '0) begin
                            state_d = DONE;
                            q_d     = '1;
                            r_d     = dif.in_x;
                            dz_d    = 1'b1;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_d = rem_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                        q_d     = quo_fix;
                        r_d     = rem_fix;
                        dz_d    = 1'b0;
                    end
                end
                DONE: begin
                    if (dif.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge div_clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            ymag_q  <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            ymag_q  <= ymag_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign dif.in_ready  = (state_q == IDLE);
    assign dif.busy      = (state_q == BUSY);
    assign dif.out_valid = (state_q == DONE);
    assign dif.out_q     = q_q;
    assign dif.out_r     = r_q;
    assign dif.out_dz    = dz_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised sequential radix-2 integer divider, successor to the fixed 32-bit iterative divider in the execute stage. Accepts a WIDTH-bit signed or unsigned division through a valid/ready handshake and performs one restoring iteration per cycle. It holds the result until the consumer takes it, supports a pipeline flush that aborts an in-flight operation, and completes division by zero in one cycle with a flag. Instantiated beside the multiplier to serve DIV/DIVU and write HI/LO.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 2..64

- div_clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  divider can accept; high only in IDLE
- in_signed  in  1  1 = two's-complement division, 0 = unsigned
- in_x  in  WIDTH  dividend
- in_y  in  WIDTH  divisor
- flush  in  1  abort the current operation and discard its result
- out_valid  out  1  result available; high only in DONE
- out_ready  in  1  consumer takes the result
- out_q  out  WIDTH  quotient
- out_r  out  WIDTH  remainder
- out_dz  out  1  divisor was zero
- busy  out  1  high in BUSY

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - Acceptance occurs when in_valid & in_ready & ~flush.
  - Register the operand signs: sx = in_signed & in_x[MSB] and sy = in_signed & in_y[MSB].
  - Register the magnitudes |x| and |y| as WIDTH-bit unsigned values. |MIN| = 2^(WIDTH-1), unsigned.
  - Clear the iteration counter.
  - If in_y == 0, go to DONE with out_q = all-ones, out_r = in_x (unmodified), out_dz = 1.
  - Otherwise go to BUSY.
- BUSY: each cycle performs one restoring step on a 2*WIDTH-bit partial remainder.
  - The step shifts in one quotient bit: 1 iff the trial subtraction is non-negative.
  - The counter runs 0..WIDTH-1.
  - On the step with counter = WIDTH-1, register the sign-corrected results and go to DONE:
    - out_q = (sx ^ sy) ? -q : q
    - out_r = sx ? -r : r
    - out_dz = 0
- DONE: outputs stay stable while out_ready is low. On out_valid & out_ready, go to IDLE.
- Arithmetic semantics:
  - Quotient truncates toward zero; a nonzero remainder takes the sign of the dividend.
  - The invariant x = q*y + r holds modulo 2^WIDTH.
  - Signed MIN / -1 gives q = MIN and r = 0. This falls out of the magnitude path with no special case.
- flush:
  - In any state, flush forces IDLE on the next edge. out_valid never rises for the aborted operation.
  - flush takes priority over in_valid and over out_ready in the same cycle.
  - In IDLE, flush blocks acceptance.
- rst behaves like flush, and additionally zeroes every register.

## Timing
- Reset values:
  - in_ready = 1
  - busy = 0
  - out_valid = 0
  - out_q = 0, out_r = 0, out_dz = 0
- Operands are sampled on acceptance edge E0 only. in_x, in_y and in_signed may change afterwards.
- Nonzero divisor: BUSY during the cycles after E0 through edge E0+WIDTH. out_valid is first high in the cycle after edge E0+WIDTH, giving a latency of WIDTH+1 edges.
- Zero divisor: out_valid is high in the cycle after E0, a latency of 1 edge.
- After a result is taken at edge Et, in_ready is high in the cycle after Et. There is no same-cycle re-accept, so throughput is one operation per WIDTH+2 cycles.
- in_ready, out_valid and busy are decoded from registered state only, with no combinational path from inputs.
- out_q, out_r and out_dz change only on the edge entering DONE, or on reset.

## Structure
- Package div_pkg holds:
  - the state typedef (IDLE/BUSY/DONE);
  - a function for the counter width, $clog2(WIDTH).
- Sub-module div_negate(WIDTH): a conditional two's-complement negate (en ? ~a+1 : a).
  - Instantiated four times: |x|, |y|, quotient fix-up and remainder fix-up.
- The remainder datapath is a single 2*WIDTH-bit register. Do not use separate shift and difference registers.

## Test plan
- WIDTH=32, unsigned 100 / 7:
  - out_q = 14 and out_r = 2.
  - out_valid first high exactly 33 edges after acceptance.
  - busy high for 32 cycles.
- Signed cases, WIDTH=32:
  - -7 / 2: q = 0xFFFFFFFD, r = 0xFFFFFFFF.
  - 7 / -2: q = 0xFFFFFFFD, r = 1.
  - 0x80000000 / 0xFFFFFFFF: q = 0x80000000, r = 0.
  - Unsigned 0xFFFFFFFF / 1: q = 0xFFFFFFFF, r = 0.
- Divide by zero, signed 5 / 0:
  - out_valid one edge after acceptance.
  - q = 0xFFFFFFFF, r = 5, out_dz = 1, busy never high.
- Flush at counter = 10:
  - IDLE on the next edge; in_ready = 1; out_valid never rises.
  - A following 9 / 3 yields q = 3, r = 0.
  - Also cover flush in DONE: the held result is dropped.
- Backpressure:
  - Hold out_ready low for 5 cycles in DONE. Outputs stay constant and in_ready stays 0.
  - Toggling in_x/in_y during BUSY does not affect the result.
- WIDTH=8 instance:
  - Exhaustive signed and unsigned sweep against a reference model, checking q and r.
  - Latency is 9 edges for nonzero divisors.
  - Assert rst mid-BUSY: all outputs return to their reset values on the next edge.
